hs_ready_pipe: RTL and testbench
================================

Name: hs_ready_pipe

Overview:
- Single-entry valid/ready bridge between an upstream producer (pre-stage) and a downstream consumer (post-stage).
- Breaks the combinational ready path: the upstream ready is driven purely from a register.
- Data and valid bypass combinationally when the buffer is empty, giving zero latency.
- Sits between a handshake sender and a handshake receiver in any streaming pipeline.

Parameters:
- DATA_W, 8: payload width in bits.
- CNT_W, 16: width of the statistics counters (used only with HS_READY_PIPE_STATS_EN).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- valid_pre_i  in  1  upstream data valid.
- data_pre_i  in  DATA_W  upstream payload.
- ready_pre_o  out  1  ready to upstream; registered, with no combinational path from any input.
- valid_post_o  out  1  valid to downstream.
- data_post_o  out  DATA_W  payload to downstream.
- ready_post_i  in  1  downstream ready.
- (stats only) in_xfer_cnt  out  CNT_W  number of accepted upstream transfers.
- (stats only) out_xfer_cnt  out  CNT_W  number of completed downstream transfers.
- (stats only) stall_cnt  out  CNT_W  cycles with valid_post_o=1 and ready_post_i=0.

Behaviour:
- State: buf_valid (1 bit) and buf_data (DATA_W bits).
- Reset (async assert): buf_valid=0, buf_data=0.
  - While in reset: ready_pre_o=1.
  - valid_post_o and data_post_o follow valid_pre_i and data_pre_i.
  - Any buffered word is discarded. The same applies to a reset asserted mid-operation.
- ready_pre_o = ~buf_valid.
- valid_post_o = buf_valid | valid_pre_i.
- data_post_o = buf_valid ? buf_data : data_pre_i.
- Transfer definitions:
  - Upstream transfer: valid_pre_i & ready_pre_o at a clock edge.
  - Downstream transfer: valid_post_o & ready_post_i at a clock edge.
- Buffer empty (buf_valid=0):
  - valid_pre_i=1, ready_post_i=1: word passes through in the same cycle; buffer stays empty.
  - valid_pre_i=1, ready_post_i=0: word is captured; buf_valid<=1, buf_data<=data_pre_i.
  - valid_pre_i=0: no change.
- Buffer full (buf_valid=1):
  - Upstream is stalled (ready_pre_o=0); valid_pre_i and data_pre_i are ignored.
  - ready_post_i=1: buffered word is delivered; buf_valid<=0.
  - ready_post_i=0: buffer holds; data_post_o stays stable.
- Ordering is strictly preserved:
  - No word bypasses a full buffer.
  - Every accepted word is delivered exactly once.
  - Nothing is dropped or duplicated.
- Upstream valid may drop without a transfer (the sender is not required to hold valid). Downstream valid never drops while the buffer is full and unaccepted.
- Throughput: one word per cycle sustained when ready_post_i is held at 1.
- Cost: after a stall, one bubble cycle on upstream acceptance, while the buffer drains.
- Latency: 0 cycles via bypass; 1 or more cycles when buffered.

Optional Feature:
- HS_READY_PIPE_STATS_EN defined:
  - Adds the three counter outputs.
  - Counters reset to 0 asynchronously, increment by 1 on their event, and wrap modulo 2^CNT_W.
- Not defined:
  - The counter ports and logic are absent.
  - Core behaviour is identical in both builds.

Decomposition:
- Shared package hs_pkg:
  - Default DATA_W and CNT_W constants.
  - Typedef hs_data_t (logic [DATA_W-1:0]).
  - Helper function computing the transfer fire signal (valid & ready).
- One natural sub-module: hs_ready_pipe_stats, holding the three counters, instantiated only under the macro.
- The core buffer logic remains in hs_ready_pipe.

Test Plan:
- Reset:
  - Drive rst=1 with valid_pre_i=1, data_pre_i=0x5A, ready_post_i=0 → ready_pre_o=1, valid_post_o=1, data_post_o=0x5A.
  - Release reset → buffer empty.
- Bypass: ready_post_i=1 held, upstream sends 0x01, 0x02, 0x03 on consecutive cycles → each appears on data_post_o the same cycle; ready_pre_o stays 1.
- Capture and stall:
  - Send 0x10 with ready_post_i=0 → next cycle ready_pre_o=0, valid_post_o=1, data_post_o=0x10.
  - Change data_pre_i to 0x11 → data_post_o remains 0x10.
- Drain:
  - From the full state, set ready_post_i=1 → 0x10 delivered and ready_pre_o=1 the next cycle.
  - 0x11 is accepted only after that point; the received order is 0x10 then 0x11.
- Random stalls: independent random stalls on upstream valid and downstream ready for 150 cycles with an incrementing 8-bit source sequence → the received sequence is contiguous and identical to the source, with no loss or duplication, and ready_pre_o never changes combinationally.
- Stats build (HS_READY_PIPE_STATS_EN): 5 words sent with 3 downstream stall cycles → in_xfer_cnt=5, out_xfer_cnt=5, stall_cnt=3.

Source files
------------

// File: rtl/hs_pkg.sv
// Shared handshake definitions: default widths, payload type and the transfer-fire helper.
package hs_pkg;

  localparam int HS_DATA_W = 8;
  localparam int HS_CNT_W  = 16;

  typedef logic [HS_DATA_W-1:0] hs_data_t;

  function automatic logic hs_fire(input logic valid, input logic ready);
    return valid & ready;
  endfunction

endpackage

// File: rtl/hs_ready_pipe_stats.sv
// Transfer and stall counters for hs_ready_pipe; instantiated only when HS_READY_PIPE_STATS_EN is defined.
module hs_ready_pipe_stats #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_in_fire,
  input  logic             i_out_fire,
  input  logic             i_stall,
  output logic [CNT_W-1:0] o_in_xfer_cnt,
  output logic [CNT_W-1:0] o_out_xfer_cnt,
  output logic [CNT_W-1:0] o_stall_cnt
);

  logic [CNT_W-1:0] r_in_cnt;
  logic [CNT_W-1:0] r_out_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  // Counters wrap naturally modulo 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_cnt    <= '0;
      r_out_cnt   <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (i_in_fire)  r_in_cnt    <= r_in_cnt + 1'b1;
      if (i_out_fire) r_out_cnt   <= r_out_cnt + 1'b1;
      if (i_stall)    r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign o_in_xfer_cnt  = r_in_cnt;
  assign o_out_xfer_cnt = r_out_cnt;
  assign o_stall_cnt    = r_stall_cnt;

endmodule

// File: rtl/hs_ready_pipe.sv
// Single-entry valid/ready skid bridge: registered upstream ready, zero-latency bypass when empty.
// Optional statistics counters are enabled with the HS_READY_PIPE_STATS_EN macro.
module hs_ready_pipe
  import hs_pkg::*;
#(
  parameter int DATA_W = HS_DATA_W
`ifdef HS_READY_PIPE_STATS_EN
  ,
  parameter int CNT_W  = HS_CNT_W
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_pre_i,
  input  logic [DATA_W-1:0] data_pre_i,
  output logic              ready_pre_o,
  output logic              valid_post_o,
  output logic [DATA_W-1:0] data_post_o,
  input  logic              ready_post_i
`ifdef HS_READY_PIPE_STATS_EN
  ,
  output logic [CNT_W-1:0]  in_xfer_cnt,
  output logic [CNT_W-1:0]  out_xfer_cnt,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  logic              r_buf_valid;
  logic [DATA_W-1:0] r_buf_data;

  // Ready depends only on the buffer flag, so no input reaches it combinationally.
  assign ready_pre_o  = ~r_buf_valid;
  assign valid_post_o = r_buf_valid | valid_pre_i;
  assign data_post_o  = r_buf_valid ? r_buf_data : data_pre_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf_valid <= 1'b0;
      r_buf_data  <= '0;
    end else if (!r_buf_valid) begin
      // Capture only when the word cannot pass straight through.
      if (valid_pre_i && !ready_post_i) begin
        r_buf_valid <= 1'b1;
        r_buf_data  <= data_pre_i;
      end
    end else if (ready_post_i) begin
      r_buf_valid <= 1'b0;
    end
  end

`ifdef HS_READY_PIPE_STATS_EN
  logic w_in_fire;
  logic w_out_fire;
  logic w_stall;

  assign w_in_fire  = hs_fire(valid_pre_i, ready_pre_o);
  assign w_out_fire = hs_fire(valid_post_o, ready_post_i);
  assign w_stall    = valid_post_o & ~ready_post_i;

  hs_ready_pipe_stats #(
    .CNT_W(CNT_W)
  ) u_stats (
    .clk            (clk),
    .rst            (rst),
    .i_in_fire      (w_in_fire),
    .i_out_fire     (w_out_fire),
    .i_stall        (w_stall),
    .o_in_xfer_cnt  (in_xfer_cnt),
    .o_out_xfer_cnt (out_xfer_cnt),
    .o_stall_cnt    (stall_cnt)
  );
`endif

endmodule

// File: tb/tb_hs_ready_pipe.sv
// Self-checking bench for hs_ready_pipe: directed reset/bypass/stall/drain steps, then randomized
// stalls against a word-count scoreboard. Stats checks run when HS_READY_PIPE_STATS_EN is defined.
module tb_hs_ready_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid_pre_i;
  logic [7:0] data_pre_i;
  logic       ready_pre_o;
  logic       valid_post_o;
  logic [7:0] data_post_o;
  logic       ready_post_i;
`ifdef HS_READY_PIPE_STATS_EN
  logic [15:0] in_xfer_cnt;
  logic [15:0] out_xfer_cnt;
  logic [15:0] stall_cnt;
`endif

  hs_ready_pipe dut (
    .clk          (clk),
    .rst          (rst),
    .valid_pre_i  (valid_pre_i),
    .data_pre_i   (data_pre_i),
    .ready_pre_o  (ready_pre_o),
    .valid_post_o (valid_post_o),
    .data_post_o  (data_post_o),
    .ready_post_i (ready_post_i)
`ifdef HS_READY_PIPE_STATS_EN
    ,
    .in_xfer_cnt  (in_xfer_cnt),
    .out_xfer_cnt (out_xfer_cnt),
    .stall_cnt    (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Scoreboard: every accepted word is appended; words still owed downstream = acc - del.
  logic [7:0] words[$];
  logic [7:0] rcv[$];
  int acc, del;
  int m_in, m_out, m_stall;
  bit random_mode;
  logic [7:0] rcv_next;
  logic [7:0] src;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_clear();
    words.delete();
    rcv.delete();
    acc = 0; del = 0;
    m_in = 0; m_out = 0; m_stall = 0;
  endtask

  // One clock cycle: drive inputs, check outputs, update the scoreboard, advance past the edge.
  task automatic step(input logic v, input logic [7:0] d, input logic r);
    int   pend;
    logic exp_rdy, exp_v;
    logic [7:0] exp_d;
    valid_pre_i  = v;
    data_pre_i   = d;
    ready_post_i = r;
    #1;
    pend    = acc - del;
    exp_rdy = (pend == 0);
    exp_v   = (pend > 0) || v;
    exp_d   = (pend > 0) ? words[del] : d;
    chk("ready_pre", ready_pre_o, exp_rdy);
    chk("valid_post", valid_post_o, exp_v);
    chk("data_post", data_post_o, exp_d);
    // Flip both inputs: the upstream ready must not move.
    valid_pre_i  = ~v;
    ready_post_i = ~r;
    #1;
    chk("ready_no_comb", ready_pre_o, exp_rdy);
    valid_pre_i  = v;
    ready_post_i = r;
    #1;
    if (v && exp_rdy) begin
      words.push_back(d);
      acc++;
      m_in++;
    end
    if (exp_v && r) begin
      rcv.push_back(data_post_o);
      if (random_mode) begin
        chk("order", data_post_o, rcv_next);
        rcv_next++;
      end
      del++;
      m_out++;
    end
    if (exp_v && !r) m_stall++;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    chk("rst_ready_pre", ready_pre_o, 1'b1);
    chk("rst_valid_post", valid_post_o, valid_pre_i);
    chk("rst_data_post", data_post_o, data_pre_i);
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
  endtask

  initial begin
    logic [7:0] exp_seq[5];
    rst          = 1'b0;
    valid_pre_i  = 1'b1;
    data_pre_i   = 8'h5A;
    ready_post_i = 1'b0;
    random_mode  = 1'b0;
    rcv_next     = 8'h00;
    src          = 8'h00;
    model_clear();
    #3;
    apply_reset();
    chk("post_rst_empty", ready_pre_o, 1'b1);

    // Bypass, then capture/stall, then drain.
    step(1'b1, 8'h01, 1'b1);
    step(1'b1, 8'h02, 1'b1);
    step(1'b1, 8'h03, 1'b1);
    step(1'b1, 8'h10, 1'b0);
    chk("captured_full", ready_pre_o, 1'b0);
    step(1'b1, 8'h11, 1'b0);
    chk("hold_data", data_post_o, 8'h10);
    step(1'b1, 8'h11, 1'b1);
    chk("drained_ready", ready_pre_o, 1'b1);
    step(1'b1, 8'h11, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    exp_seq = '{8'h01, 8'h02, 8'h03, 8'h10, 8'h11};
    chk("directed_count", rcv.size(), 5);
    for (int i = 0; i < 5 && i < rcv.size(); i++) chk("directed_order", rcv[i], exp_seq[i]);

    // Reset mid-operation with a word buffered: it must be discarded.
    step(1'b1, 8'hEE, 1'b0);
    chk("mid_full", ready_pre_o, 1'b0);
    valid_pre_i = 1'b0;
    data_pre_i  = 8'h33;
    apply_reset();
    chk("mid_rst_empty", valid_post_o, 1'b0);

    // Randomized stalls on both sides with an incrementing source.
    random_mode = 1'b1;
    rcv_next    = 8'h00;
    src         = 8'h00;
    for (int c = 0; c < 150; c++) begin
      logic v, r;
      int   acc_before;
      v = ($urandom_range(0, 99) < 60);
      r = ($urandom_range(0, 99) < 55);
      acc_before = acc;
      step(v, v ? src : 8'($urandom), r);
      if (acc != acc_before) src++;
    end
    for (int c = 0; c < 4; c++) step(1'b0, 8'h00, 1'b1);
    random_mode = 1'b0;
    chk("rand_no_loss", del, acc);
    chk("rand_count", rcv.size(), acc);
    chk("rand_last", rcv_next, src);

`ifdef HS_READY_PIPE_STATS_EN
    chk("stats_rand_in", in_xfer_cnt, 16'(m_in));
    chk("stats_rand_out", out_xfer_cnt, 16'(m_out));
    chk("stats_rand_stall", stall_cnt, 16'(m_stall));
    valid_pre_i = 1'b0;
    apply_reset();
    chk("stats_rst_in", in_xfer_cnt, 16'd0);
    step(1'b1, 8'hA0, 1'b1);
    step(1'b1, 8'hA1, 1'b0);
    step(1'b1, 8'hA2, 1'b0);
    step(1'b1, 8'hA2, 1'b1);
    step(1'b1, 8'hA2, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'hA3, 1'b1);
    step(1'b1, 8'hA4, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    chk("stats_in", in_xfer_cnt, 16'd5);
    chk("stats_out", out_xfer_cnt, 16'd5);
    chk("stats_stall", stall_cnt, 16'd3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
